// File: rtl/hazard_ctrl.sv
// Stateful hazard controller: per-stage flush/stall vectors, load-use penalty,
// fence.i drain sequencing, back-end stall watchdog and perf counters.
module hazard_ctrl #(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CSR_WAIT_WB     = 1,
   parameter int WDOG_LIMIT      = 1024,
   parameter int WDOG_WIDTH      = 16,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ibus_waitrequest,
   input  logic                 lsu_stall_req,
   input  logic                 md_busy,
   input  logic                 load_use_req,
   input  logic                 ex_csr_read,
   input  logic                 mem_csr_read,
   input  logic                 wb_csr_read,
   input  logic                 fence_i_req,
   input  logic                 pipe_empty,
   input  logic                 branch_take,
   input  logic                 trap_take,
   output logic [4:0]           stage_flush,
   output logic [4:0]           stage_stall,
   output logic                 icache_inv,
   output logic                 wdog_timeout,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
);

   localparam logic [2:0]            LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);
   localparam logic [WDOG_WIDTH-1:0] WDOG_TRIP = WDOG_WIDTH'(WDOG_LIMIT);
   localparam logic                  WAIT_WB   = (CSR_WAIT_WB != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      INV   = 2'd2
   } fence_state_t;

   fence_state_t          state;
   fence_state_t          state_next;
   logic [2:0]            lu_cnt;
   logic [2:0]            lu_cnt_next;
   logic [WDOG_WIDTH-1:0] wdog_cnt;
   logic [WDOG_WIDTH-1:0] wdog_next;

   logic be_stall;
   logic csr_hold;
   logic lu_active;
   logic fence_drain;
   logic front_hold;
   logic redirect;

   assign be_stall    = lsu_stall_req | md_busy;
   assign csr_hold    = ex_csr_read | mem_csr_read | (WAIT_WB & wb_csr_read);
   assign lu_active   = load_use_req | (lu_cnt != 3'd0);
   assign fence_drain = (state == DRAIN) | (state == INV);
   assign front_hold  = lu_active | csr_hold | fence_drain;
   assign redirect    = branch_take | trap_take;
   assign icache_inv  = (state == INV);

   always_comb begin
      stage_flush    = 5'b00000;
      stage_flush[0] = redirect | (state == INV)
                     | (ibus_waitrequest & ~front_hold & ~be_stall);
      stage_flush[1] = redirect | (front_hold & ~be_stall);
      stage_flush[2] = trap_take;
      stage_flush[3] = trap_take;
      stage_stall    = 5'b00000;
      stage_stall[0] = ibus_waitrequest | be_stall | front_hold;
      stage_stall[1] = be_stall;
      stage_stall[2] = be_stall;
      stage_stall[3] = be_stall;
   end

   // A redirect kills the pending penalty; back-end stalls freeze it.
   always_comb begin
      lu_cnt_next = lu_cnt;
      if (redirect) begin
         lu_cnt_next = 3'd0;
      end else if (!be_stall) begin
         if (lu_cnt != 3'd0) begin
            lu_cnt_next = lu_cnt - 3'd1;
         end else if (load_use_req) begin
            lu_cnt_next = LU_RELOAD;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fence_i_req & ~redirect) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (redirect) begin
               state_next = IDLE;
            end else if (pipe_empty) begin
               state_next = INV;
            end
         end
         INV:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wdog_next = '0;
      if (be_stall) begin
         wdog_next = (wdog_cnt == '1) ? wdog_cnt : wdog_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lu_cnt       <= 3'd0;
         wdog_cnt     <= '0;
         wdog_timeout <= 1'b0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state        <= state_next;
         lu_cnt       <= lu_cnt_next;
         wdog_cnt     <= wdog_next;
         wdog_timeout <= wdog_timeout | (wdog_next == WDOG_TRIP);
         stall_cycles <= stall_cycles
                       + {{(CNT_WIDTH-1){1'b0}}, stage_stall[0]};
         flush_events <= flush_events
                       + {{(CNT_WIDTH-1){1'b0}}, redirect};
      end
   end

endmodule
